// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined W-bit add/subtract with carry, overflow, zero and negative
// flags, optional signed saturation and a sticky overflow flag. The carry chain is
// cut into SLICE-bit stages; operand slices not yet consumed ride along in skew
// registers and finished result slices ride along in deskew registers.
module addsub_pipe #(
  parameter int unsigned WID   = 16,
  parameter int unsigned SLICE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic           ci,
  input  logic           sat,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WID-1:0] s,
  output logic           co,
  output logic           v,
  output logic           z,
  output logic           n,
  output logic           vsticky,
  input  logic           clr_sticky
);

  if ((SLICE == 0) || ((WID % SLICE) != 0)) begin : g_bad_slice
    $error("addsub_pipe: WID must be a non-zero multiple of SLICE");
  end

  localparam int STAGES = int'(WID / SLICE);
  localparam int LAST   = STAGES - 1;
  // Inter-stage register count; kept at least 1 so the arrays stay legal at STAGES = 1.
  localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;

  // Per-stage inputs (index k = values entering stage k).
  logic [WID-1:0] st_a     [STAGES];
  logic [WID-1:0] st_b     [STAGES];  // effective B (already inverted for subtract)
  logic [WID-1:0] st_sum   [STAGES];  // result slices completed by earlier stages
  logic           st_c     [STAGES];
  logic           st_vld   [STAGES];
  logic           st_op    [STAGES];
  logic           st_sat   [STAGES];
  logic           st_am    [STAGES];
  logic           st_bm    [STAGES];

  // Per-stage outputs.
  logic [WID-1:0] st_sum_o [STAGES];
  logic           st_co    [STAGES];

  // Registers between stage k and stage k+1.
  logic [WID-1:0] mid_a_q   [MID];
  logic [WID-1:0] mid_b_q   [MID];
  logic [WID-1:0] mid_sum_q [MID];
  logic           mid_c_q   [MID];
  logic           mid_vld_q [MID];
  logic           mid_op_q  [MID];
  logic           mid_sat_q [MID];
  logic           mid_am_q  [MID];
  logic           mid_bm_q  [MID];

  // Output-stage registers.
  logic           out_valid_q;
  logic [WID-1:0] s_q;
  logic           co_q;
  logic           v_q;
  logic           z_q;
  logic           n_q;
  logic           vsticky_q;

  // Final-stage combinational results.
  logic [WID-1:0] s_d;
  logic           co_d;
  logic           v_d;
  logic           z_d;
  logic           n_d;

  logic en;

  // Whole pipe advances together; a held result blocks everything behind it.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Route each stage's inputs and add its slice with the carry from the stage below.
  always_comb begin
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE:0]   tot;
    sa  = '0;
    sb  = '0;
    tot = '0;

    st_a[0]   = a;
    st_b[0]   = op ? ~b : b;
    st_sum[0] = '0;
    st_c[0]   = ci;
    st_vld[0] = in_valid;
    st_op[0]  = op;
    st_sat[0] = sat;
    st_am[0]  = a[WID-1];
    st_bm[0]  = b[WID-1];

    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = mid_a_q[k-1];
      st_b[k]   = mid_b_q[k-1];
      st_sum[k] = mid_sum_q[k-1];
      st_c[k]   = mid_c_q[k-1];
      st_vld[k] = mid_vld_q[k-1];
      st_op[k]  = mid_op_q[k-1];
      st_sat[k] = mid_sat_q[k-1];
      st_am[k]  = mid_am_q[k-1];
      st_bm[k]  = mid_bm_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      sa          = SLICE'(st_a[k] >> (k * SLICE));
      sb          = SLICE'(st_b[k] >> (k * SLICE));
      tot         = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, st_c[k]};
      st_sum_o[k] = st_sum[k] | (WID'(tot[SLICE-1:0]) << (k * SLICE));
      st_co[k]    = tot[SLICE];
    end
  end

  // Overflow uses the original operand sign bits, so it holds for add and subtract alike.
  always_comb begin
    logic sr;
    sr   = st_sum_o[LAST][WID-1];
    co_d = st_co[LAST];
    v_d  = (st_op[LAST] ^ sr ^ st_bm[LAST]) & (~st_op[LAST] ^ st_am[LAST] ^ st_bm[LAST]);
    s_d  = st_sum_o[LAST];
    if (st_sat[LAST] && v_d) begin
      // Overflow direction follows the sign of A.
      s_d = st_am[LAST] ? {1'b1, {(WID-1){1'b0}}} : {1'b0, {(WID-1){1'b1}}};
    end
    z_d = (s_d == '0);
    n_d = s_d[WID-1];
  end

  // Skew/deskew registers between carry stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MID; k++) begin
        mid_a_q[k]   <= '0;
        mid_b_q[k]   <= '0;
        mid_sum_q[k] <= '0;
        mid_c_q[k]   <= 1'b0;
        mid_vld_q[k] <= 1'b0;
        mid_op_q[k]  <= 1'b0;
        mid_sat_q[k] <= 1'b0;
        mid_am_q[k]  <= 1'b0;
        mid_bm_q[k]  <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        mid_a_q[k]   <= st_a[k];
        mid_b_q[k]   <= st_b[k];
        mid_sum_q[k] <= st_sum_o[k];
        mid_c_q[k]   <= st_co[k];
        mid_vld_q[k] <= st_vld[k];
        mid_op_q[k]  <= st_op[k];
        mid_sat_q[k] <= st_sat[k];
        mid_am_q[k]  <= st_am[k];
        mid_bm_q[k]  <= st_bm[k];
      end
    end
  end

  // Output register; bubbles clear out_valid but leave the last result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      co_q        <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
    end else if (en) begin
      out_valid_q <= st_vld[LAST];
      if (st_vld[LAST]) begin
        s_q  <= s_d;
        co_q <= co_d;
        v_q  <= v_d;
        z_q  <= z_d;
        n_q  <= n_d;
      end
    end
  end

  // Sticky overflow: a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsticky_q <= 1'b0;
    end else begin
      vsticky_q <= (vsticky_q & ~clr_sticky) | (out_valid_q & out_ready & v_q);
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;
  assign vsticky   = vsticky_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: a 2-stage instance (WID=16, SLICE=8) and a
// single-stage instance (SLICE=WID=16) driven with the same operands.
module tb_addsub_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_valid2;
  logic        op;
  logic        ci;
  logic        sat;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;
  logic        out_ready2;
  logic        clr_sticky;

  logic        in_ready,  out_valid,  co,  v,  z,  n,  vsticky;
  logic        in_ready2, out_valid2, co2, v2, z2, n2, vsticky2;
  logic [15:0] s, s2;

  int checks;
  int failures;

  addsub_pipe #(.WID(16), .SLICE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .ci         (ci),
    .sat        (sat),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .s          (s),
    .co         (co),
    .v          (v),
    .z          (z),
    .n          (n),
    .vsticky    (vsticky),
    .clr_sticky (clr_sticky)
  );

  addsub_pipe #(.WID(16), .SLICE(16)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .op         (op),
    .ci         (ci),
    .sat        (sat),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .s          (s2),
    .co         (co2),
    .v          (v2),
    .z          (z2),
    .n          (n2),
    .vsticky    (vsticky2),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One beat into both instances; single-stage result after 1 edge, 2-stage after 2.
  task automatic run_vec(input string tag, input logic vo, input logic vc, input logic vs,
                         input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] es, input logic eco, input logic ev,
                         input logic ez, input logic en);
    @(negedge clk);
    op = vo; ci = vc; sat = vs; a = va; b = vb;
    in_valid = 1'b1; in_valid2 = 1'b1;
    #1;
    chk1({tag, ".in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_valid2 = 1'b0;
    chk1({tag, ".lat2_early"}, out_valid, 1'b0);
    chk1({tag, ".l1.valid"}, out_valid2, 1'b1);
    chk16({tag, ".l1.s"}, s2, es);
    chk1({tag, ".l1.co"}, co2, eco);
    chk1({tag, ".l1.v"}, v2, ev);
    chk1({tag, ".l1.z"}, z2, ez);
    chk1({tag, ".l1.n"}, n2, en);
    @(negedge clk);
    chk1({tag, ".valid"}, out_valid, 1'b1);
    chk16({tag, ".s"}, s, es);
    chk1({tag, ".co"}, co, eco);
    chk1({tag, ".v"}, v, ev);
    chk1({tag, ".z"}, z, ez);
    chk1({tag, ".n"}, n, en);
  endtask

  logic [15:0] sa_v [8];
  logic [3:0]  pat;
  int          sent;
  int          rcv;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    op = 1'b0; ci = 1'b0; sat = 1'b0; a = '0; b = '0;
    out_ready = 1'b1; out_ready2 = 1'b1; clr_sticky = 1'b0;
    pat = 4'b1001;  // out_ready per cycle: 1,0,0,1,...
    for (int i = 0; i < 8; i++) sa_v[i] = 16'h00F8 + 16'(i) * 16'h0101;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk1("rst.out_valid", out_valid, 1'b0);
    chk16("rst.s", s, 16'h0000);
    chk1("rst.co", co, 1'b0);
    chk1("rst.v", v, 1'b0);
    chk1("rst.z", z, 1'b0);
    chk1("rst.n", n, 1'b0);
    chk1("rst.vsticky", vsticky, 1'b0);
    chk1("rst.l1.out_valid", out_valid2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rst.in_ready", in_ready, 1'b1);

    // Signed overflow without saturation, then sticky set after acceptance.
    run_vec("add_ovf", 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk1("sticky.set", vsticky, 1'b1);
    chk1("drain.valid", out_valid, 1'b0);
    // Clear with no overflow in flight.
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk1("sticky.clr", vsticky, 1'b0);

    // Saturating add; clear asserted in the same cycle the overflow is accepted.
    run_vec("add_sat", 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk1("sticky.clr_vs_set", vsticky, 1'b1);

    // 0x8000 - 1 with no borrow: raw 0x7FFF, carry 1, saturates to signed min.
    run_vec("sub_sat", 1'b1, 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    run_vec("xslice", 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("wrap0", 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("ci_add", 1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sub_brw", 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_vec("sub_neg", 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back stream with backpressure.
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      op = 1'b0; ci = 1'b0; sat = 1'b0;
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = sa_v[sent];
        b = 16'h0008;
      end
      #1;
      chk1("stream.in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        chk16("stream.s", s, sa_v[rcv] + 16'h0008);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk16("stream.count", 16'(rcv), 16'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk1("stream.no_dup", out_valid, 1'b0);

    // Reset with two beats in flight.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h4321; b = 16'h0101;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk1("inflight.valid", out_valid, 1'b1);
    chk16("inflight.s", s, 16'h2345);
    rst_n = 1'b0;
    #1;
    chk1("arst.out_valid", out_valid, 1'b0);
    chk16("arst.s", s, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("arst.no_stale", out_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined add/subtract unit with full flag generation (carry, overflow, zero, negative), optional signed saturation and a sticky overflow flag. It extends the single-bit overflow detector to a complete W-bit datapath. The carry chain is split into SLICE-bit stages so wide operands close timing. It sits between the operand-fetch logic and the register write-back / flag register, with valid/ready handshakes on both sides.

## Interface
- WID, 16: operand/result width in bits; must be an integer multiple of SLICE (elaboration error otherwise).
- SLICE, 8: bits added per pipeline stage; STAGES = WID/SLICE (derived, ≥1).

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- op  input  1  0 = add, 1 = subtract (a − b).
- ci  input  1  carry in; for subtract 1 = no borrow (6502 convention).
- sat  input  1  1 = saturate signed result on overflow.
- a  input  WID  operand A.
- b  input  WID  operand B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- s  output  WID  result (post-saturation).
- co  output  1  carry out of MSB (pre-saturation, never modified by sat).
- v  output  1  signed overflow.
- z  output  1  s == 0 (post-saturation).
- n  output  1  s[WID-1].
- vsticky  output  1  set by any accepted result with v = 1.
- clr_sticky  input  1  synchronous clear of vsticky.

## Operation
- Effective B = op ? ~b : b; carry into slice 0 = ci.
- Stage k (0..STAGES-1) adds slice k of A and effective B plus carry registered from stage k−1. Higher slices travel through skew registers; lower result slices through deskew registers, so all WID bits of one beat leave together.
- op, sat, a[WID-1], b[WID-1] travel with the beat to the last stage.
- Overflow at last stage, using original sign bits: v = (op ^ sr ^ bm) & (~op ^ am ^ bm), sr = raw sum MSB.
- Saturation: if sat & v, s = am ? 1000…0 (signed min) : 0111…1 (signed max); otherwise s = raw sum.
- z, n computed from final s; co from raw carry out.
- vsticky next = (vsticky & ~clr_sticky) | (out_valid & out_ready & v). A same-cycle clear and new overflow leave vsticky = 1.
- Per-stage valid bits; bubbles propagate as invalid stages and are never presented on out_valid.

## Timing
- Reset (async assert): all stage valids 0, out_valid 0, s 0, co/v/z/n 0, vsticky 0; in_ready 1 once reset is released. In-flight beats are discarded; no partial result appears after reset.
- Pipeline enable: en = ~out_valid | out_ready. in_ready = en (combinational from out_ready). All stages advance together when en = 1 and hold when en = 0.
- A beat accepted on edge t (in_valid & in_ready) presents out_valid = 1 after edge t+STAGES−1; latency is STAGES cycles (1 when SLICE = WID).
- Throughput is one beat per cycle while out_ready = 1.
- Stall: out_valid & ~out_ready holds every stage and the output stable, with in_ready = 0. in_valid & ~in_ready is not a transfer; the source must hold its beat.
- Flags and s are registered and stable whenever out_valid = 1 until accepted.

## Test plan
- Add, WID=16, SLICE=8: a=0x7FFF, b=0x0001, op=0, ci=0, sat=0 -> 2 cycles later s=0x8000, v=1, n=1, z=0, co=0, vsticky=1 after acceptance.
- Same operands with sat=1 -> s=0x7FFF, v=1, n=0, co=0. Then a=0x8000, b=0x0001, op=1, ci=1, sat=1 -> s=0x8000, v=1.
- Cross-slice carry: a=0x00FF, b=0x0001, op=0, ci=0 -> s=0x0100, co=0. Then a=0xFFFF, b=0x0001 -> s=0x0000, z=1, co=1, v=0.
- Back-to-back stream of 8 beats with out_ready toggling 1,0,0,1,…: results in order, none lost or duplicated, in_ready = 0 exactly while out_valid & ~out_ready.
- clr_sticky in the same cycle as an accepted v=1 result -> vsticky stays 1. Clear with no overflow -> 0 next cycle.
- Assert rst_n low with 2 beats in flight -> out_valid 0 immediately and no stale beat after release. Repeat the add tests with SLICE=WID=16 -> latency 1.
